// File: rtl/divider_pkg.sv
// Shared types and defaults for the multi-cycle restoring divider.
package divider_pkg;

    localparam int unsigned DivWidth = 32;
    localparam int unsigned DivCntW  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module div_step #(
    parameter int unsigned WIDTH = divider_pkg::DivWidth
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign rem_sh = {rem_in, quo_in[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    // rem_in < divisor always holds, so a set top bit of diff means rem_sh < divisor.
    always_comb begin
        if (!diff[WIDTH]) begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_sh[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned divider: one quotient bit per cycle, fixed 34-cycle latency.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth,
    parameter int unsigned CNT_W = DivCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stallreq,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_q,
    output logic [WIDTH-1:0] result_r
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quot_res_q, quot_res_d;
    logic [WIDTH-1:0] rem_res_q, rem_res_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             a_neg_in, b_neg_in;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (div_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign a_neg_in = signed_op & a[WIDTH-1];
    assign b_neg_in = signed_op & b[WIDTH-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        quot_res_d = quot_res_q;
        rem_res_d  = rem_res_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    if (b == '0) begin
                        quot_res_d = '1;
                        rem_res_d  = a;
                        state_d    = StDone;
                    end else begin
                        signed_d = signed_op;
                        a_neg_d  = a_neg_in;
                        b_neg_d  = b_neg_in;
                        rem_d    = '0;
                        quo_d    = a_neg_in ? -a : a;
                        div_d    = b_neg_in ? -b : b;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quot_res_d = (signed_q && (a_neg_q != b_neg_q)) ? -quo_q : quo_q;
                rem_res_d  = (signed_q && a_neg_q) ? -rem_q : rem_q;
                state_d    = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush wins over everything; results from earlier operations are kept.
        if (flush) begin
            state_d    = StIdle;
            cnt_d      = '0;
            quot_res_d = quot_res_q;
            rem_res_d  = rem_res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            quot_res_q <= quot_res_d;
            rem_res_q  <= rem_res_d;
        end
    end

    assign stallreq  = rst_n & (((state_q == StIdle) & in_valid) |
                                (state_q == StCalc) | (state_q == StFix));
    assign out_valid = (state_q == StDone) & ~flush;
    assign result_q  = quot_res_q;
    assign result_r  = rem_res_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: checks results, latency, stall, flush and reset behaviour.
module tb_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        signed_op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        stallreq;
    logic        out_valid;
    logic [31:0] result_q;
    logic [31:0] result_r;

    int          n_checks;
    int          n_fail;
    exp_t        sb[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    divider #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .signed_op (signed_op),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .stallreq  (stallreq),
        .out_valid (out_valid),
        .result_q  (result_q),
        .result_r  (result_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_v,
                                   input logic ts);
        exp_t e;
        e.lat = (tb_v == 0) ? 1 : 34;
        if (tb_v == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = ta;
        end else if (ts) begin
            if (ta == 32'h8000_0000 && tb_v == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'h0;
            end else begin
                e.q = $signed(ta) / $signed(tb_v);
                e.r = $signed(ta) % $signed(tb_v);
            end
        end else begin
            e.q = ta / tb_v;
            e.r = ta % tb_v;
        end
        return e;
    endfunction

    // Issue one request and follow it to out_valid; flush_at>0 flushes at that cycle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                          input int flush_at);
        exp_t e;
        exp_t got_e;
        int   n;
        int   lat;
        bit   got;
        e = model(ta, tb_v, ts);
        if (flush_at > 0) e.lat = flush_at + 1 + 34;
        lat = e.lat;
        @(negedge clk);
        a = ta;
        b = tb_v;
        signed_op = ts;
        in_valid = 1'b1;
        sb.push_back(e);
        n = 0;
        got = 0;
        while (!got && n <= lat + 5) begin
            if (flush_at > 0 && n == flush_at) flush = 1'b1;
            if (flush_at > 0 && n == flush_at + 1) flush = 1'b0;
            #1;
            if (out_valid) begin
                got = 1;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    got_e = sb.pop_front();
                    check("latency", 32'(n), 32'(got_e.lat));
                    check("quotient", result_q, got_e.q);
                    check("remainder", result_r, got_e.r);
                end
                check("stall_done", 32'(stallreq), 32'd0);
            end else begin
                check("stall_busy", 32'(stallreq), 32'(n < lat));
                if (flush_at > 0 && n == flush_at + 1) begin
                    check("flush_keep_q", result_q, last_q);
                    check("flush_keep_r", result_r, last_r);
                end
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            check("timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        // in_valid stays high through DONE; it must not relaunch.
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("post_done_idle", 32'(stallreq), 32'd0);
        last_q = e.q;
        last_r = e.r;
    endtask

    initial begin
        int ov_cnt;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        signed_op = 1'b0;
        flush = 1'b0;
        a = '0;
        b = '0;
        last_q = '0;
        last_r = '0;

        #12;
        check("rst_stall", 32'(stallreq), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_q", result_q, 32'd0);
        check("rst_r", result_r, 32'd0);
        in_valid = 1'b1;
        #1;
        check("rst_stall_iv", 32'(stallreq), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'h1234, 32'd0, 1'b1, 0);
        run_op(32'h1234, 32'd0, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);

        // in_valid with flush in IDLE must not launch.
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        signed_op = 1'b0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_idle_nolaunch", 32'(stallreq), 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 0);

        // Reset in cycle 10 of CALC abandons the operation.
        @(negedge clk);
        a = 32'd1000;
        b = 32'd3;
        signed_op = 1'b0;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("pre_rst_stall", 32'(stallreq), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(stallreq), 32'd0);
        check("midrst_ov", 32'(out_valid), 32'd0);
        check("midrst_q", result_q, 32'd0);
        check("midrst_r", result_r, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("rst_no_ov", 32'(ov_cnt), 32'd0);
        last_q = '0;
        last_r = '0;
        run_op(32'd100, 32'd7, 1'b0, 0);

        // Flush in cycle 20 with in_valid held; relaunch follows.
        run_op(32'd100, 32'd7, 1'b0, 20);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
